seq_mult_ctrl: RTL and testbench

Sequential shift-and-add unsigned multiplier with a start/done handshake.
- An FSM sequences one partial-product accumulation per clock.
- Replaces the single-cycle combinational array multiplier wherever area matters more than latency.
- Produces the same full-width unsigned product as the combinational multiplier (out = a*b, 2*WIDTH bits) for identical operands.

---
 rtl/seq_mult_ctrl.sv | 83 ++++++++
 tb/tb_seq_mult_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier with a start/done handshake.
// One partial product is accumulated per clock; the product is registered on completion.
module seq_mult_ctrl #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CntW-1:0]      cnt_q;

    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_step;

    always_comb begin
        addend    = {{WIDTH{1'b0}}, a_q} << cnt_q;
        acc_next  = b_q[0] ? (acc_q + addend) : acc_q;
        last_step = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_next;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CntW'(1);
                    // Final step publishes the sum including this step's partial product.
                    if (last_step) begin
                        out     <= acc_next;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: WIDTH=3 and WIDTH=8 instances share one clock and reset.
// The driver queues expected products with their due cycle; a monitor checks every done pulse.
module tb_seq_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_s [2];
    logic [7:0]  a_s [2];
    logic [7:0]  b_s [2];
    logic        busy_s [2];
    logic        done_s [2];
    logic [5:0]  out3;
    logic [15:0] out8;

    int n_checks;
    int n_fail;
    int cyc;
    int ndone [2];

    typedef struct {
        int d;
        int val;
        int due;
    } exp_t;

    exp_t q [$];

    seq_mult_ctrl #(.WIDTH(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s[0]),
        .a     (a_s[0][2:0]),
        .b     (b_s[0][2:0]),
        .busy  (busy_s[0]),
        .done  (done_s[0]),
        .out   (out3)
    );

    seq_mult_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s[1]),
        .a     (a_s[1]),
        .b     (b_s[1]),
        .busy  (busy_s[1]),
        .done  (done_s[1]),
        .out   (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] out_of(input int d);
        return (d == 0) ? 32'(out3) : 32'(out8);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (done_s[d] === 1'b1) begin
                ndone[d]++;
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("done_dut", 32'(d), 32'(e.d));
                    check("product", out_of(d), 32'(e.val));
                    check("done_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
        if (q.size() > 0 && cyc > q[0].due) begin
            e = q.pop_front();
            check("missing_done", 32'(cyc), 32'(e.due));
        end
    end

    // Starts one multiply and returns #1 after the edge where the DUT is IDLE again.
    task automatic issue(input int d, input int av, input int bv, input int exp);
        int w;
        w = (d == 0) ? 3 : 8;
        start_s[d] = 1'b1;
        a_s[d]     = 8'(av);
        b_s[d]     = 8'(bv);
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        a_s[d]     = ~8'(av);
        b_s[d]     = ~8'(bv);
        check("busy_after_start", 32'(busy_s[d]), 32'd1);
        q.push_back('{d: d, val: exp, due: cyc + w});
        repeat (w + 1) @(posedge clk);
        #1;
        check("busy_back_idle", 32'(busy_s[d]), 32'd0);
    endtask

    initial begin
        int base;
        n_checks = 0;
        n_fail   = 0;
        ndone[0] = 0;
        ndone[1] = 0;
        rst_n      = 1'b0;
        start_s[0] = 1'b1;
        a_s[0]     = 8'd7;
        b_s[0]     = 8'd7;
        start_s[1] = 1'b0;
        a_s[1]     = 8'd0;
        b_s[1]     = 8'd0;

        // Reset held with start asserted
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_done", 32'(done_s[0]), 32'd0);
        check("rst_out", out_of(0), 32'd0);
        check("rst_out8", out_of(1), 32'd0);
        rst_n = 1'b1;
        issue(0, 7, 7, 49);

        // Zero and identity
        issue(0, 0, 5, 0);
        issue(0, 1, 6, 6);
        issue(0, 5, 3, 15);

        // Start while busy is ignored
        start_s[0] = 1'b1;
        a_s[0]     = 8'd5;
        b_s[0]     = 8'd3;
        @(posedge clk);
        #1;
        q.push_back('{d: 0, val: 15, due: cyc + 3});
        a_s[0] = 8'd7;
        b_s[0] = 8'd2;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        @(posedge clk);
        #1;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        @(posedge clk);
        #1;
        check("reject_out_held", out_of(0), 32'd15);
        issue(0, 7, 2, 14);

        // Reset during CALC aborts
        start_s[0] = 1'b1;
        a_s[0]     = 8'd6;
        b_s[0]     = 8'd6;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy_s[0]), 32'd0);
        check("midrst_done", 32'(done_s[0]), 32'd0);
        check("midrst_out", out_of(0), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_out_after", out_of(0), 32'd0);
        issue(0, 6, 6, 36);

        // Exhaustive WIDTH=3, back to back
        base = ndone[0];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                issue(0, i, j, i * j);
            end
        end
        check("exhaustive_done_count", 32'(ndone[0] - base), 32'd64);

        // WIDTH=8 instance
        issue(1, 255, 255, 65025);
        issue(1, 128, 2, 256);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
